// File: rtl/bus_cycle_if.sv
// Handshake and bus signal bundle for bus_cycle_unit.
// The master modport is the bus cycle unit itself, which drives the bus strobes.
// The slave modport is the environment: the control unit, the datapath and the bus slave.
interface bus_cycle_if;
  logic        cedbi;
  logic        req_rd;
  logic        req_wr;
  logic        req_byte;
  logic [15:0] dba;
  logic [15:0] dbo;
  logic [15:0] dbi;
  logic        din_active;
  logic        busy;
  logic        done;
  logic        buserr;
  logic [15:0] ad_o;
  logic [15:0] ad_i;
  logic        ad_oe;
  logic        sync;
  logic        din;
  logic        dout;
  logic        wtbt;
  logic        rply;

  modport master (
    input  cedbi, req_rd, req_wr, req_byte, dba, dbo, ad_i, rply,
    output dbi, din_active, busy, done, buserr, ad_o, ad_oe, sync, din, dout, wtbt
  );

  modport slave (
    output cedbi, req_rd, req_wr, req_byte, dba, dbo, ad_i, rply,
    input  dbi, din_active, busy, done, buserr, ad_o, ad_oe, sync, din, dout, wtbt
  );
endinterface

// File: rtl/bus_cycle_unit.sv
// bus_cycle_unit: runs one SYNC/DIN/DOUT/WTBT/RPLY handshake bus cycle per
// accepted request. It returns read data on dbi, and it reports a missing or
// stuck RPLY as a one-cycle buserr pulse. All outputs are registered, and every
// output except the synchronizer advances only on cedbi.
module bus_cycle_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_SETUP     = 1
) (
  input logic         clkdbi,
  input logic         reset_n,
  bus_cycle_if.master bus
);

  localparam logic [7:0] SETUP_LAST   = 8'(ADDR_SETUP - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_END  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [15:0] addr_r, addr_s;
  logic [15:0] data_r, data_s;
  logic        byte_r, byte_s;
  logic        rd_r, rd_s;

  logic [1:0]  rply_sync_r;
  logic        rply_s;

  logic [15:0] dbi_r, dbi_s;
  logic [15:0] ad_o_r, ad_o_s;
  logic        din_active_r, din_active_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        buserr_r, buserr_s;
  logic        ad_oe_r, ad_oe_s;
  logic        sync_r, sync_s;
  logic        din_r, din_s;
  logic        dout_r, dout_s;
  logic        wtbt_r, wtbt_s;

  assign rply_s = rply_sync_r[1];

  // Two-flop synchronizer for the asynchronous reply; samples on every edge, ignoring cedbi.
  always_ff @(posedge clkdbi or negedge reset_n) begin
    if (!reset_n) begin
      rply_sync_r <= 2'b00;
    end else begin
      rply_sync_r <= {rply_sync_r[0], bus.rply};
    end
  end

  // State register, shared setup/timeout counter and the request latches.
  always_ff @(posedge clkdbi or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      addr_r  <= 16'd0;
      data_r  <= 16'd0;
      byte_r  <= 1'b0;
      rd_r    <= 1'b0;
    end else if (bus.cedbi) begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      byte_r  <= byte_s;
      rd_r    <= rd_s;
    end
  end

  // Next-state logic. An exit on reply takes priority over a timeout on the same edge.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    data_s  = data_r;
    byte_s  = byte_r;
    rd_s    = rd_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_rd || bus.req_wr) begin
          state_s = ST_ADDR;
          cnt_s   = 8'd0;
          addr_s  = bus.dba;
          data_s  = bus.dbo;
          byte_s  = bus.req_byte;
          rd_s    = bus.req_rd;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (cnt_r == SETUP_LAST) begin
          state_s = ST_DATA;
          cnt_s   = 8'd0;
        end else begin
          cnt_s   = cnt_r + 8'd1;
        end
      end
      ST_DATA: begin
        cnt_s = cnt_r + 8'd1;
        if (rply_s) begin
          state_s = ST_END;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_END: begin
        cnt_s = cnt_r + 8'd1;
        if (!rply_s) begin
          state_s = ST_IDLE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_END;
        end
      end
      ST_ERR: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming state. These are registered so that the strobes change on the transition edge.
  always_comb begin
    sync_s       = 1'b0;
    din_s        = 1'b0;
    dout_s       = 1'b0;
    wtbt_s       = 1'b0;
    ad_oe_s      = 1'b0;
    ad_o_s       = ad_o_r;
    done_s       = 1'b0;
    buserr_s     = 1'b0;
    din_active_s = 1'b0;
    busy_s       = (state_s != ST_IDLE);
    if ((state_r == ST_DATA) && (state_s == ST_END) && rd_r) begin
      if (byte_r) begin
        dbi_s = {8'h00, (addr_r[0] ? bus.ad_i[15:8] : bus.ad_i[7:0])};
      end else begin
        dbi_s = bus.ad_i;
      end
    end else begin
      dbi_s = dbi_r;
    end
    case (state_s)
      ST_ADDR: begin
        sync_s  = 1'b1;
        ad_oe_s = 1'b1;
        ad_o_s  = addr_s;
        wtbt_s  = ~rd_s;
      end
      ST_DATA: begin
        sync_s = 1'b1;
        if (rd_s) begin
          din_s = 1'b1;
        end else begin
          dout_s  = 1'b1;
          ad_oe_s = 1'b1;
          wtbt_s  = byte_s;
          ad_o_s  = (byte_s && addr_s[0]) ? {data_s[7:0], data_s[7:0]} : data_s;
        end
      end
      ST_END: begin
        sync_s = 1'b1;
      end
      ST_ERR: begin
        buserr_s = 1'b1;
      end
      ST_IDLE: begin
        if (state_r == ST_END) begin
          done_s       = 1'b1;
          din_active_s = rd_r;
          busy_s       = 1'b1;
        end else begin
          done_s       = 1'b0;
        end
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output registers. They hold while cedbi is low, and reset drops every strobe at once.
  always_ff @(posedge clkdbi or negedge reset_n) begin
    if (!reset_n) begin
      dbi_r        <= 16'd0;
      ad_o_r       <= 16'd0;
      din_active_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      buserr_r     <= 1'b0;
      ad_oe_r      <= 1'b0;
      sync_r       <= 1'b0;
      din_r        <= 1'b0;
      dout_r       <= 1'b0;
      wtbt_r       <= 1'b0;
    end else if (bus.cedbi) begin
      dbi_r        <= dbi_s;
      ad_o_r       <= ad_o_s;
      din_active_r <= din_active_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      buserr_r     <= buserr_s;
      ad_oe_r      <= ad_oe_s;
      sync_r       <= sync_s;
      din_r        <= din_s;
      dout_r       <= dout_s;
      wtbt_r       <= wtbt_s;
    end
  end

  assign bus.dbi        = dbi_r;
  assign bus.ad_o       = ad_o_r;
  assign bus.din_active = din_active_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.buserr     = buserr_r;
  assign bus.ad_oe      = ad_oe_r;
  assign bus.sync       = sync_r;
  assign bus.din        = din_r;
  assign bus.dout       = dout_r;
  assign bus.wtbt       = wtbt_r;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Scoreboard bench for bus_cycle_unit. The stimulus side pushes the expected
// outcome of every accepted request. A negedge monitor pops one entry on each
// done/buserr pulse and compares it with the bus activity it recorded.
module tb_bus_cycle_unit;
  localparam int TO = 64;

  logic clkdbi;
  logic reset_n;
  bus_cycle_if bus ();

  bus_cycle_unit #(.TIMEOUT_CYCLES(TO), .ADDR_SETUP(1)) dut (
    .clkdbi (clkdbi),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    bit          is_rd;
    bit          is_err;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          wtbt_d;
    logic [15:0] dbi;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_dbi = 16'd0;

  // Slave controls: mode 0 = normal reply, 1 = never reply, 2 = reply stuck until SYNC drops.
  int          slv_mode = 0;
  int          slv_rise = 0;
  int          slv_fall = 0;
  logic [15:0] slv_data = 16'd0;
  int          ce_mode  = 0;

  initial begin
    clkdbi = 1'b0;
    forever #5 clkdbi = ~clkdbi;
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Clock-enable driver: held at 1, toggling, or random.
  initial begin
    bus.cedbi = 1'b1;
    forever begin
      @(posedge clkdbi);
      #1;
      case (ce_mode)
        0:       bus.cedbi = 1'b1;
        1:       bus.cedbi = ~bus.cedbi;
        default: bus.cedbi = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Bus slave: raise rply some cycles after DIN/DOUT, and drop it after the strobe goes away.
  initial begin
    int s_cnt;
    s_cnt = 0;
    bus.rply = 1'b0;
    bus.ad_i = 16'd0;
    forever begin
      @(posedge clkdbi);
      #1;
      if (!bus.rply) begin
        if ((bus.din || bus.dout) && slv_mode != 1) begin
          if (s_cnt >= slv_rise) begin
            bus.rply = 1'b1;
            bus.ad_i = slv_data;
            s_cnt = 0;
          end else begin
            s_cnt++;
          end
        end else begin
          s_cnt = 0;
        end
      end else if (slv_mode == 2) begin
        if (!bus.sync) begin
          bus.rply = 1'b0;
          bus.ad_i = 16'($urandom);
        end
      end else if (!(bus.din || bus.dout)) begin
        if (s_cnt >= slv_fall) begin
          bus.rply = 1'b0;
          bus.ad_i = 16'($urandom);
          s_cnt = 0;
        end else begin
          s_cnt++;
        end
      end else begin
        s_cnt = 0;
      end
    end
  end

  // Monitor and scoreboard checker.
  initial begin
    bit          ce_pend, ce_edge, p_sync, p_data, p_ev, ev;
    int          data_edges, ev_edges;
    logic [15:0] obs_addr, obs_data;
    bit          obs_addr_oe, obs_wtbt_a, obs_wtbt_d, obs_data_oe, obs_rd, obs_order;
    exp_t        e;
    ce_pend = 0; p_sync = 0; p_data = 0; p_ev = 0;
    data_edges = 0; ev_edges = 0;
    obs_addr = 16'd0; obs_data = 16'd0;
    obs_addr_oe = 0; obs_wtbt_a = 0; obs_wtbt_d = 0; obs_data_oe = 0; obs_rd = 0; obs_order = 0;
    forever begin
      @(negedge clkdbi);
      ce_edge = ce_pend;
      ce_pend = bus.cedbi;
      if (ce_edge) data_edges++;
      if (p_ev && ce_edge) ev_edges++;
      if (bus.sync && !p_sync) begin
        obs_addr = bus.ad_o; obs_addr_oe = bus.ad_oe; obs_wtbt_a = bus.wtbt;
      end
      if ((bus.din || bus.dout) && !p_data) begin
        data_edges = 0;
        obs_data = bus.ad_o; obs_data_oe = bus.ad_oe; obs_wtbt_d = bus.wtbt;
        obs_rd = bus.din; obs_order = p_sync && bus.sync;
      end
      ev = bus.done || bus.buserr;
      if (ev && !p_ev) begin
        ev_edges = 0;
        check("event_expected", 40'(exp_q.size() != 0), 40'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("kind_done_buserr", {bus.done, bus.buserr}, e.is_err ? 2'b01 : 2'b10);
          check("dbi", bus.dbi, e.dbi);
          check("din_active", bus.din_active, (e.is_rd && !e.is_err));
          check("busy_at_end", bus.busy, 1'b1);
          check("addr_phase", {obs_addr_oe, obs_wtbt_a, obs_addr}, {1'b1, !e.is_rd, e.addr});
          check("op_strobe", obs_rd, e.is_rd);
          check("sync_before_data", obs_order, 1'b1);
          check("strobes_off", {bus.sync, bus.din, bus.dout, bus.wtbt, bus.ad_oe}, 5'd0);
          if (!e.is_rd) begin
            check("data_phase", {obs_data_oe, obs_wtbt_d, obs_data}, {1'b1, e.wtbt_d, e.wdata});
          end
          if (e.is_err) begin
            check("timeout_ce_cycles", 40'(data_edges), 40'(TO));
          end
        end
      end
      if (!ev && p_ev) begin
        check("pulse_ce_cycles", 40'(ev_edges), 40'd1);
      end
      p_sync = bus.sync;
      p_data = bus.din || bus.dout;
      p_ev = ev;
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.busy === 1'b1 && t < 4000) begin
      @(posedge clkdbi);
      #2;
      t++;
    end
    if (t >= 4000) check("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic do_txn(input bit rd, input bit wr, input bit byt, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] rdata, input int mode,
                        input int rise, input int fall, input bit push);
    exp_t e;
    int   t;
    wait_idle();
    slv_mode = mode; slv_rise = rise; slv_fall = fall; slv_data = rdata;
    bus.req_rd = rd; bus.req_wr = wr; bus.req_byte = byt; bus.dba = a; bus.dbo = d;
    t = 0;
    do begin
      @(posedge clkdbi);
      #2;
      t++;
    end while (bus.busy !== 1'b1 && t < 1000);
    if (t >= 1000) check("accept_timeout", bus.busy, 1'b1);
    bus.req_rd = 1'b0; bus.req_wr = 1'b0;
    bus.req_byte = 1'($urandom); bus.dba = 16'($urandom); bus.dbo = 16'($urandom);
    e.is_rd  = rd;
    e.is_err = (mode != 0);
    e.addr   = a;
    e.wtbt_d = byt;
    e.wdata  = (byt && a[0]) ? {d[7:0], d[7:0]} : d;
    if (rd && mode != 1) begin
      model_dbi = byt ? (((a[0] ? (rdata >> 8) : rdata)) & 16'h00FF) : rdata;
    end
    e.dbi = model_dbi;
    if (push) exp_q.push_back(e);
  endtask

  // Stimulus.
  initial begin
    int t;
    bus.req_rd = 1'b0; bus.req_wr = 1'b0; bus.req_byte = 1'b0;
    bus.dba = 16'd0; bus.dbo = 16'd0;
    reset_n = 1'b0;
    repeat (3) @(posedge clkdbi);
    #2;
    check("reset_data", {bus.dbi, bus.ad_o}, 32'd0);
    check("reset_ctrl", {bus.ad_oe, bus.sync, bus.din, bus.dout, bus.wtbt,
                         bus.busy, bus.done, bus.buserr, bus.din_active}, 9'd0);
    reset_n = 1'b1;
    @(posedge clkdbi);
    #2;

    // Word read, word write, odd byte write, odd byte read.
    do_txn(1, 0, 0, 16'o177660, 16'h1234, 16'o123456, 0, 3, 1, 1);
    do_txn(0, 1, 0, 16'o001000, 16'o052525, 16'h0000, 0, 2, 1, 1);
    do_txn(0, 1, 1, 16'o001001, 16'o000377, 16'h0000, 0, 1, 0, 1);
    do_txn(1, 0, 1, 16'o001001, 16'h0000, 16'hAB12, 0, 2, 2, 1);
    do_txn(1, 0, 1, 16'o001000, 16'h0000, 16'hCD34, 0, 0, 0, 1);

    // Timeouts: no reply, then reply stuck high through END.
    do_txn(1, 0, 0, 16'o004000, 16'h0000, 16'h5555, 1, 0, 0, 1);
    do_txn(1, 0, 0, 16'o004002, 16'h0000, 16'h7E81, 2, 1, 0, 1);

    // Read wins over write; a request while busy is ignored.
    do_txn(1, 1, 0, 16'o002000, 16'h0F0F, 16'h3C3C, 0, 4, 1, 1);
    bus.req_wr = 1'b1; bus.dba = 16'o003000;
    repeat (4) @(posedge clkdbi);
    #2;
    bus.req_wr = 1'b0;
    wait_idle();

    // Clock enable toggling every cycle.
    ce_mode = 1;
    do_txn(1, 0, 0, 16'o177660, 16'h0000, 16'o123456, 0, 3, 1, 1);
    wait_idle();
    ce_mode = 0;

    // Reset while in DATA: strobes drop at once and nothing is reported.
    do_txn(1, 0, 0, 16'o005000, 16'h0000, 16'h0000, 1, 0, 0, 0);
    t = 0;
    while (!bus.din && t < 200) begin
      @(posedge clkdbi);
      #2;
      t++;
    end
    check("reached_data", bus.din, 1'b1);
    repeat (2) @(posedge clkdbi);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_strobes", {bus.sync, bus.din, bus.dout, bus.wtbt, bus.ad_oe,
                            bus.busy, bus.done, bus.buserr}, 8'd0);
    model_dbi = 16'd0;
    repeat (3) @(posedge clkdbi);
    #2;
    check("reset_dbi", bus.dbi, 16'd0);
    reset_n = 1'b1;
    do_txn(1, 0, 0, 16'o006000, 16'h0000, 16'h9A5B, 0, 1, 1, 1);

    // Random traffic with a random clock enable.
    ce_mode = 2;
    for (int i = 0; i < 40; i++) begin
      bit rd, wr;
      int mode;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      mode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_txn(rd, wr, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
             mode, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1);
    end
    wait_idle();
    ce_mode = 0;
    repeat (10) @(posedge clkdbi);
    #2;
    check("all_events_seen", 40'(exp_q.size()), 40'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog for the whole run.
  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_cycle_unit.md
# bus_cycle_unit

Bus interface stage directly downstream of the CPU datapath. Takes the datapath's bus address (dba), write data (dbo) and a read/write request from the control unit, and runs one asynchronous-handshake bus cycle (SYNC / DIN / DOUT / WTBT / RPLY). It returns read data on dbi together with the din_active select the datapath uses to bypass its dbi register. A missing or stuck RPLY is reported as a one-cycle bus-error pulse, which the control unit turns into a bus trap.

## Interface
- TIMEOUT_CYCLES, 64: ce-qualified cycles allowed between DATA entry and cycle end before bus error (range 2..255).
- ADDR_SETUP, 1: ce-qualified cycles SYNC/address held before DIN/DOUT (range 1..15).
- clkdbi  in  1  clock; all state on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- cedbi  in  1  clock enable; the FSM, counters, done and buserr advance only when 1.
- req_rd  in  1  start read cycle (sampled in IDLE).
- req_wr  in  1  start write cycle (sampled in IDLE).
- req_byte  in  1  byte transfer.
- dba  in  16  bus address, latched at request accept.
- dbo  in  16  write data, latched at request accept.
- dbi  out  16  read data, holds last completed read.
- din_active  out  1  high while the completing read's data is on dbi in the done cycle.
- busy  out  1  FSM not IDLE.
- done  out  1  cycle completed normally.
- buserr  out  1  cycle aborted by timeout.
- ad_o  out  16  bus address/data out.
- ad_i  in  16  bus data in.
- ad_oe  out  1  ad_o drive enable.
- sync, din, dout, wtbt  out  1 each  bus strobes, active-high.
- rply  in  1  asynchronous slave reply, active-high.

## Operation
- rply passes through a 2-flop synchronizer clocked every clkdbi edge (not ce-gated), producing rply_s.
- States: IDLE, ADDR, DATA, END, ERR.
- IDLE: on cedbi and (req_rd or req_wr), latch dba→a_q, dbo→d_q, req_byte→b_q, and op (read if req_rd, so read wins when both are set), then go to ADDR. Requests while busy are ignored.
- ADDR: sync=1, ad_oe=1, ad_o=a_q; wtbt=1 for writes (address-phase write flag). After ADDR_SETUP ce cycles, go to DATA and clear the timeout counter.
- DATA, read: sync=1, ad_oe=0, din=1.
- DATA, write: sync=1, ad_oe=1, dout=1, wtbt=b_q, ad_o=d_q. For a byte write to an odd address (a_q[0]=1), ad_o={d_q[7:0],d_q[7:0]}.
- DATA, either op: on ce with rply_s=1, go to END. A read also captures ad_i→dbi; for a byte read, dbi={8'b0, a_q[0]?ad_i[15:8]:ad_i[7:0]}.
- END: din/dout/wtbt=0, ad_oe=0, sync=1. On ce with rply_s=0: sync=0, done=1 (and din_active=1 if read), go to IDLE.
- Timeout: an 8-bit counter increments on each ce cycle in DATA and END. If it reaches TIMEOUT_CYCLES before exit, go to ERR, where all strobes and ad_oe are 0, buserr=1, dbi is unchanged, and the next ce cycle returns to IDLE.
- done and buserr are never both 1. Exactly one of them fires per accepted request.

## Timing
- Reset values: dbi=0, ad_o=0, ad_oe=0, sync=din=dout=wtbt=0, busy=0, done=0, buserr=0, din_active=0, state IDLE, synchronizer=0.
- Asynchronous reset mid-cycle drops every strobe immediately; no done or buserr is issued for the aborted cycle.
- done, buserr and din_active are registered. Each is high from the ce edge that sets it until the next ce edge.
- busy=1 from the accept edge through the done/buserr cycle's end. A new request can be accepted on the ce edge that clears done.
- Minimum read latency with cedbi=1, ADDR_SETUP=1, and rply already high at DATA entry:
  - accept at edge 0;
  - ADDR during cycle 1;
  - DATA at 2, where rply_s is seen and dbi captured;
  - END at 3, which waits for rply_s low (bus dependent, at least 2 extra edges through the synchronizer);
  - done in the cycle after END exits.
- When cedbi=0, state, counter and outputs hold. The synchronizer still samples.

## Test plan
- Word read: cedbi=1, req_rd, dba=0o177660, slave answers ad_i=0o123456 and raises rply 3 cycles after din. Required: sync then din, dbi=0o123456 with din_active=1 and done=1 for one cycle, busy then 0.
- Word write: req_wr, dba=0o001000, dbo=0o052525. Required: ad_o=0o001000 during ADDR with wtbt=1; ad_o=0o052525 with dout=1 and wtbt=0 in DATA; done after rply falls; no din_active.
- Byte write to odd address: dba=0o001001, dbo=0o000377, req_byte=1. Required: data phase ad_o=0o177777 (0xFFFF) with wtbt=1. A byte read from 0o001001 with ad_i=0xAB12 returns dbi=0x00AB.
- Timeout: req_rd, rply held 0, TIMEOUT_CYCLES=64. Required: buserr pulses exactly 64 ce cycles after DATA entry, strobes drop, no done, dbi unchanged. Repeat with rply stuck 1 in END: buserr after 64.
- Simultaneous req_rd=req_wr=1, plus a new request while busy: a read is performed, and the second request is ignored (exactly one done).
- cedbi toggling 1/0 during a read: same final dbi and stroke order, with latency doubled. Assert reset_n=0 while in DATA: all strobes 0 at once, no done/buserr, then a clean cycle after release.
